qam_mapper: RTL and testbench

- Maps a bit stream onto constellation points and feeds the pilot-insertion stage directly.
- Accepts 32-bit words of raw (interleaved) data bits over the codebase's WB-style streaming handshake.
- Emits one complex Q1.15 symbol per output beat, formatted {Im[31:16], Re[15:0]}, which is the format the pilot-insertion stage consumes.
- Supports BPSK, QPSK and 16-QAM, selected per frame. Counts 192 data symbols per OFDM symbol.

---
 rtl/ofdm_pkg.sv | 43 ++++
 rtl/qam_lut.sv | 44 ++++
 rtl/qam_mapper.sv | 125 ++++++++++++
 tb/tb_qam_mapper.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_pkg.sv
// Shared OFDM definitions: Q1.15 constellation amplitudes, OFDM sizing and
// the modulation-select encoding used by the mapper and its lookup table.
package ofdm_pkg;

  localparam int N_FFT  = 256;
  localparam int N_DATA = 192;  // 256 - DC null - 55 guard nulls - 8 pilots

  // Q1.15 amplitudes and their negations
  localparam logic [15:0] P_1  = 16'h7FFF;
  localparam logic [15:0] N_1  = 16'h8001;
  localparam logic [15:0] P_Q  = 16'h5A82;
  localparam logic [15:0] N_Q  = 16'hA57E;
  localparam logic [15:0] P_A1 = 16'h287A;
  localparam logic [15:0] N_A1 = 16'hD786;
  localparam logic [15:0] P_A3 = 16'h796E;
  localparam logic [15:0] N_A3 = 16'h8692;

  localparam logic [1:0] MOD_BPSK  = 2'b00;
  localparam logic [1:0] MOD_QPSK  = 2'b01;
  localparam logic [1:0] MOD_QAM16 = 2'b10;

  // The reserved encoding 2'b11 behaves as QPSK.
  function automatic logic [1:0] mod_sanitize(input logic [1:0] m);
    return (m == 2'b11) ? MOD_QPSK : m;
  endfunction

  function automatic logic [2:0] bits_per_sym(input logic [1:0] m);
    case (m)
      MOD_BPSK:  return 3'd1;
      MOD_QAM16: return 3'd4;
      default:   return 3'd2;
    endcase
  endfunction

  function automatic logic [5:0] syms_per_word(input logic [1:0] m);
    case (m)
      MOD_BPSK:  return 6'd32;
      MOD_QAM16: return 6'd8;
      default:   return 6'd16;
    endcase
  endfunction

endpackage

// File: rtl/qam_lut.sv
// Combinational constellation lookup.
//   mode : modulation (MOD_BPSK / MOD_QPSK / MOD_QAM16, 11 acts as QPSK)
//   bits : symbol bits, bit 0 is the first bit of the symbol
//   sym  : {Im[31:16], Re[15:0]} in Q1.15
module qam_lut
  import ofdm_pkg::*;
(
  input  logic [1:0]  mode,
  input  logic [3:0]  bits,
  output logic [31:0] sym
);

  // 16-QAM axis, Gray coded: the first bit gives the sign, the second bit
  // selects the inner (1) or outer (0) ring.
  function automatic logic [15:0] qam_level(input logic b_sign, input logic b_inner);
    if (b_inner) return b_sign ? P_A1 : N_A1;
    else         return b_sign ? P_A3 : N_A3;
  endfunction

  logic [15:0] re;
  logic [15:0] im;

  always_comb begin
    re = N_Q;
    im = N_Q;
    case (mode)
      MOD_BPSK: begin
        re = bits[0] ? P_1 : N_1;
        im = 16'h0000;
      end
      MOD_QAM16: begin
        re = qam_level(bits[0], bits[1]);
        im = qam_level(bits[2], bits[3]);
      end
      default: begin
        re = bits[0] ? P_Q : N_Q;
        im = bits[1] ? P_Q : N_Q;
      end
    endcase
  end

  assign sym = {im, re};

endmodule

// File: rtl/qam_mapper.sv
// Bit-to-constellation mapper feeding the pilot-insertion stage.
//   CLK_I, RST_I (async, active-low)
//   Input  stream : DAT_I[31:0], CYC_I, STB_I, WE_I -> ACK_O ; MOD_I[1:0]
//   Output stream : DAT_O[31:0] {Im,Re}, CYC_O, STB_O, WE_O <- ACK_I
//   SYM_DONE_O    : one-cycle pulse after the N_DATA-th symbol is accepted
//
// Handshake: a beat transfers on a rising clock edge where the producer's
// STB (with CYC and WE on the input side) and the consumer's ACK are both
// high. Once STB_O is raised, DAT_O and STB_O hold until ACK_I is seen.
module qam_mapper
  import ofdm_pkg::*;
(
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [31:0] DAT_I,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  output logic        ACK_O,
  input  logic [1:0]  MOD_I,
  output logic [31:0] DAT_O,
  output logic        CYC_O,
  output logic        STB_O,
  output logic        WE_O,
  input  logic        ACK_I,
  output logic        SYM_DONE_O
);

  logic        icyc;       // CYC_I delayed, for rising-edge detection
  logic        pend;       // frame start seen while previous frame drains
  logic [1:0]  pend_mode;
  logic [1:0]  mode;
  logic [31:0] wbuf;
  logic [5:0]  rem;        // symbols still to emit from wbuf
  logic [7:0]  sym_cnt;
  logic [31:0] lut_sym;

  logic       ena, adv, busy, cyc_rise, start, hold;
  logic [1:0] start_mode, mode_eff;

  assign ena      = CYC_I & STB_I & WE_I;
  assign adv      = ~STB_O | ACK_I;
  assign busy     = (rem != 6'd0) | STB_O;
  assign cyc_rise = CYC_I & ~icyc;
  // A new frame starts only once nothing of the previous one is left.
  assign start    = ~busy & (cyc_rise | pend);
  assign hold     = pend | (cyc_rise & busy);

  assign start_mode = pend ? pend_mode : mod_sanitize(MOD_I);
  // A word accepted on the frame-start edge is sized by the new mode.
  assign mode_eff   = start ? start_mode : mode;

  // Accept when the buffer is empty, or when its last symbol leaves now.
  assign ACK_O = RST_I & ena & ~hold &
                 ((rem == 6'd0) | ((rem == 6'd1) & adv));

  assign WE_O = STB_O;

  qam_lut u_lut (
    .mode (mode),
    .bits (wbuf[3:0]),
    .sym  (lut_sym)
  );

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      icyc       <= 1'b0;
      pend       <= 1'b0;
      pend_mode  <= MOD_QPSK;
      mode       <= MOD_QPSK;
      wbuf       <= 32'h0;
      rem        <= 6'd0;
      sym_cnt    <= 8'd0;
      DAT_O      <= 32'h0;
      STB_O      <= 1'b0;
      CYC_O      <= 1'b0;
      SYM_DONE_O <= 1'b0;
    end else begin
      icyc  <= CYC_I;
      CYC_O <= CYC_I | busy;

      if (cyc_rise & busy) begin
        pend      <= 1'b1;
        pend_mode <= mod_sanitize(MOD_I);
      end else if (start) begin
        pend <= 1'b0;
      end

      if (start) mode <= start_mode;

      // start implies STB_O is low, so clear and increment never collide
      SYM_DONE_O <= 1'b0;
      if (start) begin
        sym_cnt <= 8'd0;
      end else if (STB_O & ACK_I) begin
        if (sym_cnt == 8'(N_DATA - 1)) begin
          sym_cnt    <= 8'd0;
          SYM_DONE_O <= 1'b1;
        end else begin
          sym_cnt <= sym_cnt + 8'd1;
        end
      end

      if (adv) begin
        if (rem != 6'd0) begin
          DAT_O <= lut_sym;
          STB_O <= 1'b1;
        end else begin
          STB_O <= 1'b0;
        end
      end

      // The last symbol is mapped from the old wbuf on the same edge that
      // reloads it, so back-to-back words have no gap.
      if (ACK_O) begin
        wbuf <= DAT_I;
        rem  <= syms_per_word(mode_eff);
      end else if ((rem != 6'd0) & adv) begin
        wbuf <= wbuf >> bits_per_sym(mode);
        rem  <= rem - 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_qam_mapper.sv
module tb_qam_mapper;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b0;
  logic [31:0] DAT_I = 32'h0;
  logic        CYC_I = 1'b0;
  logic        STB_I = 1'b0;
  logic        WE_I  = 1'b0;
  logic        ACK_O;
  logic [1:0]  MOD_I = 2'b00;
  logic [31:0] DAT_O;
  logic        CYC_O;
  logic        STB_O;
  logic        WE_O;
  logic        ACK_I = 1'b1;
  logic        SYM_DONE_O;

  qam_mapper dut (
    .CLK_I      (CLK_I),
    .RST_I      (RST_I),
    .DAT_I      (DAT_I),
    .CYC_I      (CYC_I),
    .STB_I      (STB_I),
    .WE_I       (WE_I),
    .ACK_O      (ACK_O),
    .MOD_I      (MOD_I),
    .DAT_O      (DAT_O),
    .CYC_O      (CYC_O),
    .STB_O      (STB_O),
    .WE_O       (WE_O),
    .ACK_I      (ACK_I),
    .SYM_DONE_O (SYM_DONE_O)
  );

  // ---------------- clock ----------------
  always #5 CLK_I = ~CLK_I;

  // ---------------- scoreboard state ----------------
  int          ncmp = 0;
  int          nerr = 0;
  logic [31:0] exp_q[$];
  logic [1:0]  cur_mode = 2'b01;
  int          acc_cnt  = 0;
  int          done_cnt = 0;
  int          done_at  = 0;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic timeout_fail(input string tag);
    ncmp++;
    nerr++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  // ---------------- reference constellation ----------------
  // Axis level from the bit pair written first-bit-first: 00 -3, 01 -1, 11 +1, 10 +3
  function automatic logic [15:0] lvl16(input logic b_first, input logic b_second);
    case ({b_first, b_second})
      2'b00:   return 16'h8692;
      2'b01:   return 16'hD786;
      2'b11:   return 16'h287A;
      default: return 16'h796E;
    endcase
  endfunction

  function automatic logic [31:0] ref_sym(input logic [1:0] m, input logic [3:0] nib);
    case (m)
      2'b00:   return {16'h0000, (nib[0] ? 16'h7FFF : 16'h8001)};
      2'b10:   return {lvl16(nib[2], nib[3]), lvl16(nib[0], nib[1])};
      default: return {(nib[1] ? 16'h5A82 : 16'hA57E), (nib[0] ? 16'h5A82 : 16'hA57E)};
    endcase
  endfunction

  function automatic int ref_bps(input logic [1:0] m);
    case (m)
      2'b00:   return 1;
      2'b10:   return 4;
      default: return 2;
    endcase
  endfunction

  task automatic push_word(input logic [31:0] w);
    logic [31:0] t;
    int          b;
    b = ref_bps(cur_mode);
    t = w;
    for (int k = 0; k < 32 / b; k++) begin
      exp_q.push_back(ref_sym(cur_mode, t[3:0]));
      t = t >> b;
    end
  endtask

  // ---------------- driver tasks ----------------
  // Offers a word and waits for ACK_O; returns the number of falling edges
  // sampled up to and including the one that saw ACK_O.
  task automatic send_word(input logic [31:0] w, input bit last, output int waited);
    DAT_I  = w;
    STB_I  = 1'b1;
    WE_I   = 1'b1;
    waited = 0;
    for (int j = 1; j <= 300; j++) begin
      @(negedge CLK_I);
      if (ACK_O) begin
        waited = j;
        break;
      end
    end
    if (waited == 0) begin
      timeout_fail("ack_wait");
      STB_I = 1'b0;
    end else begin
      @(posedge CLK_I);
      push_word(w);
      #1;
      if (last) STB_I = 1'b0;
    end
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int j = 0; j < 2000; j++) begin
      @(negedge CLK_I);
      if (!STB_O && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("drain");
  endtask

  task automatic start_frame(input logic [1:0] m);
    bit ok;
    wait_drain();
    CYC_I = 1'b0;
    ok = 1'b0;
    for (int j = 0; j < 50; j++) begin
      @(negedge CLK_I);
      if (!CYC_O) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("cyc_low");
    @(posedge CLK_I);
    #1;
    MOD_I    = m;
    cur_mode = m;
    CYC_I    = 1'b1;
    @(posedge CLK_I);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge CLK_I) begin
    if (RST_I) begin
      if (STB_O && ACK_I) begin
        check32("we_o", {31'b0, WE_O}, 32'h1);
        if (exp_q.size() == 0) begin
          ncmp++;
          nerr++;
          $error("FAIL extra_symbol observed=%h expected=none", DAT_O);
        end else begin
          check32("sym", DAT_O, exp_q.pop_front());
        end
        acc_cnt++;
      end
      if (SYM_DONE_O) begin
        done_cnt++;
        done_at = acc_cnt;
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int          c;
    logic [31:0] held;
    logic [31:0] w;
    bit          ok;

    // reset state
    repeat (3) @(posedge CLK_I);
    #1;
    check32("rst_stb",  {31'b0, STB_O}, 32'h0);
    check32("rst_cyc",  {31'b0, CYC_O}, 32'h0);
    check32("rst_ack",  {31'b0, ACK_O}, 32'h0);
    check32("rst_dat",  DAT_O, 32'h0);
    check32("rst_done", {31'b0, SYM_DONE_O}, 32'h0);
    check32("rst_mode", {30'b0, dut.mode}, 32'h1);
    RST_I = 1'b1;
    @(posedge CLK_I);
    #1;

    // QPSK: single set bit, then an all-zero word
    start_frame(2'b01);
    send_word(32'h0000_0001, 1'b0, c);
    @(negedge CLK_I);
    check32("qpsk_latency", {31'b0, STB_O}, 32'h0);
    @(negedge CLK_I);
    check32("qpsk_stb", {31'b0, STB_O}, 32'h1);
    check32("qpsk_first", DAT_O, 32'hA57E_5A82);
    send_word(32'h0000_0000, 1'b1, c);
    check32("qpsk_reack", c, 14);
    wait_drain();
    check32("qpsk_cnt", {24'b0, dut.sym_cnt}, 32'd32);

    // 16-QAM: two back-to-back words, mid-frame MOD_I change ignored
    start_frame(2'b10);
    MOD_I = 2'b00;
    send_word(32'hFEDC_BA98, 1'b0, c);
    @(negedge CLK_I);
    @(negedge CLK_I);
    check32("qam_first", DAT_O, 32'hD786_8692);
    send_word(32'h0123_4567, 1'b1, c);
    check32("qam_b2b", c, 6);
    @(negedge CLK_I);
    check32("qam_nogap0", {31'b0, STB_O}, 32'h1);
    @(negedge CLK_I);
    check32("qam_nogap1", {31'b0, STB_O}, 32'h1);
    check32("qam_w2_first", DAT_O, 32'h796E_287A);

    // BPSK: all ones then all zeros
    start_frame(2'b00);
    send_word(32'hFFFF_FFFF, 1'b0, c);
    @(negedge CLK_I);
    @(negedge CLK_I);
    check32("bpsk_first", DAT_O, 32'h0000_7FFF);
    send_word(32'h0000_0000, 1'b1, c);
    check32("bpsk_reack", c, 30);

    // New frame (QPSK) requested while the BPSK frame still drains
    CYC_I = 1'b0;
    @(posedge CLK_I);
    #1;
    MOD_I    = 2'b01;
    cur_mode = 2'b01;
    CYC_I    = 1'b1;
    send_word(32'h1234_5678, 1'b0, c);
    check32("defer_ack", {31'b0, (c > 20)}, 32'h1);
    check32("defer_cnt_clr", {24'b0, dut.sym_cnt}, 32'h0);

    // Back-pressure mid-word with the next word already offered
    repeat (3) @(posedge CLK_I);
    #1;
    ACK_I = 1'b0;
    DAT_I = 32'hCAFE_F00D;
    STB_I = 1'b1;
    @(negedge CLK_I);
    held = DAT_O;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK_I);
      check32("bp_hold", DAT_O, held);
      check32("bp_stb", {31'b0, STB_O}, 32'h1);
      check32("bp_ack", {31'b0, ACK_O}, 32'h0);
    end
    ACK_I = 1'b1;
    send_word(32'hCAFE_F00D, 1'b1, c);

    // Full OFDM symbol: 12 QPSK words = 192 symbols
    start_frame(2'b01);
    done_cnt = 0;
    acc_cnt  = 0;
    for (int i = 0; i < 12; i++) begin
      w = 32'h9E37_79B9 * 32'(i + 1);
      send_word(w, (i == 11), c);
    end
    CYC_I = 1'b0;
    ok = 1'b0;
    for (int j = 0; j < 100; j++) begin
      @(negedge CLK_I);
      if (!STB_O) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("frame_drain");
    check32("cyc_hold", {31'b0, CYC_O}, 32'h1);
    @(negedge CLK_I);
    check32("cyc_fall", {31'b0, CYC_O}, 32'h0);
    check32("done_cnt", done_cnt, 1);
    check32("done_at", done_at, 192);
    check32("cnt_wrap", {24'b0, dut.sym_cnt}, 32'h0);
    check32("frame_q", exp_q.size(), 0);

    // Reset mid-word, then a fresh 16-QAM frame
    start_frame(2'b01);
    send_word(32'hAAAA_5555, 1'b1, c);
    repeat (4) @(posedge CLK_I);
    #1;
    RST_I = 1'b0;
    #1;
    check32("mrst_stb", {31'b0, STB_O}, 32'h0);
    check32("mrst_dat", DAT_O, 32'h0);
    check32("mrst_cyc", {31'b0, CYC_O}, 32'h0);
    check32("mrst_ack", {31'b0, ACK_O}, 32'h0);
    exp_q.delete();
    CYC_I = 1'b0;
    repeat (2) @(posedge CLK_I);
    #1;
    RST_I = 1'b1;
    @(negedge CLK_I);
    @(negedge CLK_I);
    check32("mrst_no_stb", {31'b0, STB_O}, 32'h0);
    start_frame(2'b10);
    send_word(32'h8421_0F3C, 1'b1, c);
    check32("mrst_cnt0", {24'b0, dut.sym_cnt}, 32'h0);
    @(negedge CLK_I);
    @(negedge CLK_I);
    check32("mrst_qam_first", DAT_O, 32'h287A_8692);
    wait_drain();
    check32("mrst_cnt8", {24'b0, dut.sym_cnt}, 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
